// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared loader FSM encoding and instruction memory geometry
package imem_loader_pkg;
  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 32;
  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;
endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer: assembles little-endian bytes into one instruction word
module imem_word_packer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_byte_en,
  input  logic [7:0]        i_byte,
  output logic [DATA_W-1:0] o_word,
  output logic              o_word_full
);
  localparam int CW = $clog2(DATA_W / 8);
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_word;
  always_ff @(posedge clk)
    if (rst || i_clear) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_byte_en) begin
      r_word[8*r_cnt +: 8] <= i_byte;
      r_cnt                <= r_cnt + CW'(1);
    end
  assign o_word      = r_word;
  assign o_word_full = i_byte_en && r_cnt == CW'(DATA_W / 8 - 1);
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams program bytes into instruction memory while holding the CPU
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W:0]   i_num_words,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte_data,
  output logic              o_byte_ready,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_cpu_hold,
  output logic              o_done
);
  state_t            r_state, w_next;
  logic [ADDR_W:0]   r_word_cnt, r_num_words, w_cnt_inc;
  logic              w_accept, w_full, w_launch;
  logic [DATA_W-1:0] w_word;
  assign w_launch  = r_state == IDLE && i_start;
  assign w_accept  = i_byte_valid && o_byte_ready;
  assign w_cnt_inc = r_word_cnt + (ADDR_W + 1)'(1);
  imem_word_packer #(.DATA_W(DATA_W)) u_packer (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_launch),
    .i_byte_en  (w_accept),
    .i_byte     (i_byte_data),
    .o_word     (w_word),
    .o_word_full(w_full)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = (i_num_words == '0) ? DONE : LOAD;
      LOAD:    if (w_full) w_next = WRITE;
      WRITE:   w_next = (w_cnt_inc == r_num_words) ? DONE : LOAD;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_state     <= IDLE;
      r_word_cnt  <= '0;
      r_num_words <= '0;
    end else begin
      r_state <= w_next;
      if (w_launch) begin
        r_word_cnt  <= '0;
        r_num_words <= i_num_words;
      end else if (r_state == WRITE) r_word_cnt <= w_cnt_inc;
    end
  assign o_byte_ready = r_state == LOAD;
  assign o_mem_we     = r_state == WRITE;
  assign o_done       = r_state == DONE;
  assign o_cpu_hold   = r_state != IDLE;
  assign o_mem_wdata  = w_word;
  assign o_mem_addr   = (r_state == IDLE) ? i_fetch_addr : r_word_cnt[ADDR_W-1:0];
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: ADDR_W, default 6, word-address width of the instruction memory (64 words).
REQ-002 Parameter: DATA_W, default 32, instruction word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a program load; sampled only in IDLE.
REQ-006 num_words  input  ADDR_W+1  words to load, sampled with start; legal values 0..64.
REQ-007 byte_valid  input  1  loader byte source has a byte on byte_data.
REQ-008 byte_data  input  8  program byte, little-endian within each word.
REQ-009 byte_ready  output  1  loader accepts byte_data this cycle.
REQ-010 fetch_addr  input  ADDR_W  CPU fetch word address.
REQ-011 mem_addr  output  ADDR_W  address driven to the instruction memory.
REQ-012 mem_we  output  1  one-cycle write strobe to the instruction memory.
REQ-013 mem_wdata  output  DATA_W  assembled instruction word.
REQ-014 cpu_hold  output  1  stalls CPU PC update while the memory is owned by the loader.
REQ-015 done  output  1  one-cycle pulse when a load completes.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, WRITE and DONE.
REQ-017 IDLE: cpu_hold=0, byte_ready=0, mem_we=0, mem_addr=fetch_addr; on start=1 with num_words!=0 go to LOAD and clear byte_cnt and word_cnt.
REQ-018 IDLE with start=1 and num_words=0 SHALL go directly to DONE with no mem_we.
REQ-019 start outside IDLE SHALL be ignored.
REQ-020 LOAD: byte_ready=1; a byte transfers when byte_valid&&byte_ready; byte k (k=0..3) is stored into word bits [8k+7:8k].
REQ-021 The 4th accepted byte of a word SHALL cause a transition to WRITE on the next edge; byte_cnt wraps 3->0.
REQ-022 WRITE (exactly one cycle): mem_we=1, mem_addr=word_cnt, mem_wdata=assembled word, byte_ready=0.
REQ-023 After WRITE, word_cnt increments; if the incremented count equals num_words go to DONE, else return to LOAD.
REQ-024 A 64-word load SHALL write addresses 0..63 and SHALL NOT wrap to 0.
REQ-025 DONE (one cycle): done=1, cpu_hold=1, mem_we=0; next state IDLE.
REQ-026 In LOAD, WRITE and DONE, cpu_hold=1 and mem_addr SHALL ignore fetch_addr.
REQ-027 Stalls (byte_valid=0) in LOAD SHALL hold byte_cnt, word_cnt and the partial word indefinitely.
REQ-028 mem_we SHALL never assert outside WRITE; at most one write per 4 accepted bytes.
REQ-029 All outputs except mem_addr in IDLE SHALL be driven from registered state; the IDLE mem_addr path is combinational from fetch_addr (zero latency to the memory).

Reset
REQ-030 rst=1 SHALL force IDLE, byte_cnt=0, word_cnt=0, partial word=0, done=0, mem_we=0, byte_ready=0, cpu_hold=0.
REQ-031 rst asserted mid-load SHALL discard any partial word and issue no further mem_we; words already written remain in memory.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding (2 bits) and the ADDR_W/DATA_W defaults used by the CPU top level and the instruction memory.
REQ-033 One sub-module, imem_word_packer (byte_cnt, shift and assemble into a 32-bit word, word_full flag), SHALL be instantiated; the FSM and address mux remain in imem_loader.

Verification
REQ-034 Reset then idle: fetch_addr=6'h2D -> mem_addr=6'h2D same cycle, cpu_hold=0, mem_we=0.
REQ-035 start, num_words=2, bytes 13,00,50,00 then 93,00,10,00 back-to-back -> mem_we at addr 0 with 32'h00500013, then addr 1 with 32'h00100093, done pulse, then IDLE with cpu_hold=0.
REQ-036 Same load with byte_valid toggling 1,0,0,1 -> identical writes and data; no extra mem_we cycles.
REQ-037 num_words=64 with incrementing bytes -> 64 writes at addresses 0..63 in order, word 63 = 32'hFFFEFDFC, one done pulse.
REQ-038 rst asserted after 2 bytes of word 1 -> no mem_we afterwards, state IDLE, byte_ready=0; a new load writes address 0 correctly.
REQ-039 start=1 during LOAD, and start with num_words=0 in IDLE -> the first has no effect; the second gives a done pulse one cycle later with no mem_we.
